// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout and fetch FSM encoding.
// Imported by the fetch stage and its bus interface.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  function automatic logic [31:0] word_align(
    input logic [29:0] w
  );
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem req/ack, redirect strobe, decode handshake.
// master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  logic               redirect_valid;
  logic [31:0]        redirect_pc;

  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;
  logic [31:0]        id_pc_plus4;
  logic [5:0]         id_opcode;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic [4:0]         id_rd;
  logic [IMM_W-1:0]   id_imm;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    input  id_ready,
    output id_valid, id_instr, id_pc,
    output id_pc_plus4,
    output id_opcode, id_rs, id_rt,
    output id_rd, id_imm
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    output id_ready,
    input  id_valid, id_instr, id_pc,
    input  id_pc_plus4,
    input  id_opcode, id_rs, id_rt,
    input  id_rd, id_imm
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, instruction register,
// decode valid/ready handshake and field split for decode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  logic [1:0]         state;
  logic               run;
  logic [31:0]        pc;
  logic [31:0]        drain_addr;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;

  logic [31:0] tgt;
  logic        is_fetch;
  logic        is_hold;
  logic        is_drain;
  logic        unused_lo;

  assign tgt       = word_align(bus.redirect_pc[31:2]);
  assign unused_lo = ^bus.redirect_pc[1:0];

  assign is_fetch = (state == FETCH);
  assign is_hold  = (state == HOLD);
  assign is_drain = (state == DRAIN);

  // run gates the request off for the first cycle after reset
  assign bus.mem_req  = run & (is_fetch | is_drain);
  assign bus.mem_addr = is_drain ? drain_addr : pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      run        <= 1'b0;
      pc         <= word_align(RESET_PC[31:2]);
      drain_addr <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
    end else begin
      run <= 1'b1;
      unique case (1'b1)
        is_fetch: begin
          if (bus.redirect_valid) begin
            pc         <= tgt;
            drain_addr <= pc;
            if (run && !bus.mem_ack)
              state <= DRAIN;
          end else if (run && bus.mem_ack) begin
            id_instr <= bus.mem_rdata;
            id_pc    <= pc;
            id_valid <= 1'b1;
            pc       <= pc + PC_STEP;
            state    <= HOLD;
          end
        end
        is_hold: begin
          if (bus.redirect_valid) begin
            id_valid <= 1'b0;
            pc       <= tgt;
            state    <= FETCH;
          end else if (bus.id_ready) begin
            id_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        is_drain: begin
          if (bus.redirect_valid)
            pc <= tgt;
          if (bus.mem_ack)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.id_valid    = id_valid;
  assign bus.id_instr    = id_instr;
  assign bus.id_pc       = id_pc;
  assign bus.id_pc_plus4 = id_pc + PC_STEP;

  assign bus.id_opcode = id_instr[OP_HI:OP_LO];
  assign bus.id_rs     = id_instr[RS_HI:RS_LO];
  assign bus.id_rt     = id_instr[RT_HI:RT_LO];
  assign bus.id_rd     = id_instr[RD_HI:RD_LO];
  assign bus.id_imm    = id_instr[IMM_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table of fetches with a
// scoreboard queue, plus redirect, wrap and reset sequences.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          waits;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  vec_t        tbl[5];
  exp_t        sb[$];
  logic [31:0] model_pc;
  int          npass = 0;
  int          ntot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp)
      npass++;
    else
      $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic fetch_one(input logic [31:0] data,
                           input int waits,
                           input int hold,
                           input bit release_it);
    int   n;
    exp_t e;
    logic [31:0] held;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req", 32'(bus.mem_req), 32'd1);
    chk("addr", bus.mem_addr, model_pc);
    sb.push_back('{data, model_pc});
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(bus.mem_req), 32'd1);
      chk("wait_addr", bus.mem_addr, model_pc);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    model_pc      = model_pc + 32'd4;
    n = 0;
    while (!bus.id_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("id_valid", 32'(bus.id_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("id_instr", bus.id_instr, e.instr);
      chk("id_pc", bus.id_pc, e.pc);
      chk("id_pc_plus4", bus.id_pc_plus4, e.pc + 32'd4);
      chk("id_opcode", 32'(bus.id_opcode), 32'(e.instr[31:26]));
      chk("id_rs", 32'(bus.id_rs), 32'(e.instr[25:21]));
      chk("id_rt", 32'(bus.id_rt), 32'(e.instr[20:16]));
      chk("id_rd", 32'(bus.id_rd), 32'(e.instr[15:11]));
      chk("id_imm", 32'(bus.id_imm), 32'(e.instr[15:0]));
    end
    chk("hold_req", 32'(bus.mem_req), 32'd0);
    held = bus.id_instr;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_instr", bus.id_instr, held);
      chk("hold_req", 32'(bus.mem_req), 32'd0);
      chk("hold_valid", 32'(bus.id_valid), 32'd1);
    end
    if (release_it) begin
      bus.id_ready = 1'b1;
      @(negedge clk);
      bus.id_ready = 1'b0;
      chk("rel_valid", 32'(bus.id_valid), 32'd0);
      chk("rel_req", 32'(bus.mem_req), 32'd1);
      chk("rel_addr", bus.mem_addr, model_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h2008_1234, 1, 0};
    tbl[1] = '{32'h8C22_FFF0, 0, 5};
    tbl[2] = '{32'hAC43_0010, 2, 1};
    tbl[3] = '{32'h0064_2820, 0, 0};
    tbl[4] = '{32'hFFFF_FFFF, 1, 2};

    rst_n              = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    model_pc           = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_instr", bus.id_instr, 32'd0);
    chk("rst_pc", bus.id_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'd0);

    for (int i = 0; i < 2; i++)
      fetch_one(tbl[i].data, tbl[i].waits, tbl[i].hold, 1'b1);

    // redirect during an unacked request at addr 8
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("drain_req", 32'(bus.mem_req), 32'd1);
    chk("drain_addr", bus.mem_addr, 32'h8);
    @(negedge clk);
    chk("drain_addr2", bus.mem_addr, 32'h8);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("drain_valid", 32'(bus.id_valid), 32'd0);
    chk("drain_next_req", 32'(bus.mem_req), 32'd1);
    chk("drain_next_addr", bus.mem_addr, 32'h100);
    model_pc = 32'h100;

    for (int i = 2; i < 5; i++)
      fetch_one(tbl[i].data, tbl[i].waits, tbl[i].hold, 1'b1);

    // redirect into drain, then a newer redirect together with the ack
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    chk("dd_addr", bus.mem_addr, model_pc);
    bus.redirect_pc = 32'h0000_0302;
    bus.mem_ack     = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.mem_ack        = 1'b0;
    chk("dd_valid", 32'(bus.id_valid), 32'd0);
    chk("dd_req", 32'(bus.mem_req), 32'd1);
    chk("dd_addr2", bus.mem_addr, 32'h300);
    model_pc = 32'h300;

    // redirect in HOLD with id_ready in the same cycle squashes
    fetch_one(32'h1234_5678, 0, 1, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    bus.id_ready       = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b0;
    chk("sq_valid", 32'(bus.id_valid), 32'd0);
    chk("sq_req", 32'(bus.mem_req), 32'd1);
    chk("sq_addr", bus.mem_addr, 32'h500);
    model_pc = 32'h500;

    // redirect with ack in FETCH: data dropped, wrap target next
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    bus.mem_ack        = 1'b1;
    bus.mem_rdata      = 32'hCAFE_0001;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.mem_ack        = 1'b0;
    chk("ra_valid", 32'(bus.id_valid), 32'd0);
    chk("ra_addr", bus.mem_addr, 32'hFFFF_FFFC);
    model_pc = 32'hFFFF_FFFC;
    fetch_one(32'h0C00_0040, 0, 0, 1'b1);
    chk("wrap_addr", bus.mem_addr, 32'h0);

    // one-cycle reset mid-FETCH with a stray ack abandoned
    rst_n       = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b0;
    chk("mr_req", 32'(bus.mem_req), 32'd0);
    chk("mr_valid", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    chk("mr_req2", 32'(bus.mem_req), 32'd1);
    chk("mr_addr", bus.mem_addr, 32'h0);
    model_pc = 32'h0;
    fetch_one(32'h3C01_ABCD, 1, 0, 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
